// File: rtl/cdma_req_splitter.sv
// Splits a byte-length transfer command into beat-aligned CDMA chunk requests and tracks their completion.
// Optional macro CDMA_SPLIT_4K_EN additionally keeps every chunk inside a single 4 KiB page.
module cdma_req_splitter #(
    parameter int unsigned ADDR_BITS       = 34,
    parameter int unsigned LEN_BITS        = 17,
    parameter int unsigned CMD_LEN_BITS    = 32,
    parameter int unsigned DATA_BITS       = 512,
    parameter int unsigned CHUNK_BYTES     = 65536,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   s_cmd_valid,
    output logic                                   s_cmd_ready,
    input  logic [ADDR_BITS-1:0]                   s_cmd_addr,
    input  logic [CMD_LEN_BITS-1:0]                s_cmd_len,
    output logic                                   m_req_valid,
    input  logic                                   m_req_ready,
    output logic [ADDR_BITS-1:0]                   m_req_paddr,
    output logic [LEN_BITS-1:0]                    m_req_len,
    input  logic                                   req_done,
    output logic                                   cmd_done,
    output logic                                   busy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_underflow
);

    localparam int unsigned BEAT_BYTES = DATA_BITS / 8;
    localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                  state;
    logic [ADDR_BITS-1:0]    addr;
    logic [CMD_LEN_BITS-1:0] rem;
    logic [CNT_W-1:0]        cnt;
    logic                    ready_q;
    logic                    done_q;
    logic                    err_q;

    logic [ADDR_BITS-1:0]    addr_m;
    logic [CMD_LEN_BITS-1:0] len_m;
    logic [CMD_LEN_BITS-1:0] chunk;
    logic                    hs;
    logic                    dec;

    assign addr_m = s_cmd_addr & ~ADDR_BITS'(BEAT_BYTES - 1);
    assign len_m  = s_cmd_len & ~CMD_LEN_BITS'(BEAT_BYTES - 1);

`ifdef CDMA_SPLIT_4K_EN
    logic [CMD_LEN_BITS-1:0] page_left;
    assign page_left = CMD_LEN_BITS'(13'h1000 - {1'b0, addr[11:0]});
`endif

    always_comb begin
        chunk = (rem < CMD_LEN_BITS'(CHUNK_BYTES)) ? rem : CMD_LEN_BITS'(CHUNK_BYTES);
`ifdef CDMA_SPLIT_4K_EN
        if (chunk > page_left) chunk = page_left;
`endif
    end

    assign m_req_valid   = (state == ISSUE) && (cnt < CNT_W'(MAX_OUTSTANDING));
    assign m_req_paddr   = addr;
    assign m_req_len     = LEN_BITS'(chunk);
    assign hs            = m_req_valid && m_req_ready;
    // A done pulse with nothing in flight is flagged rather than wrapping the counter.
    assign dec           = req_done && (cnt != '0);
    assign s_cmd_ready   = ready_q;
    assign cmd_done      = done_q;
    assign busy          = (state != IDLE);
    assign outstanding   = cnt;
    assign err_underflow = err_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            addr    <= '0;
            rem     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt    <= cnt + CNT_W'(hs) - CNT_W'(dec);
            if (req_done && (cnt == '0)) err_q <= 1'b1;

            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (s_cmd_valid && ready_q) begin
                        if (len_m == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr    <= addr_m;
                            rem     <= len_m;
                            ready_q <= 1'b0;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        addr <= addr + ADDR_BITS'(chunk);
                        rem  <= rem - chunk;
                        if (rem == chunk) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdma_req_splitter.sv
// Directed self-checking bench for cdma_req_splitter (MAX_OUTSTANDING=2, 64-byte beats, 64 KiB chunks).
// Expected chunk lists follow the CDMA_SPLIT_4K_EN setting of the build.
module tb_cdma_req_splitter;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [33:0] s_cmd_addr;
    logic [31:0] s_cmd_len;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [33:0] m_req_paddr;
    logic [16:0] m_req_len;
    logic        req_done;
    logic        cmd_done;
    logic        busy;
    logic [1:0]  outstanding;
    logic        err_underflow;

    cdma_req_splitter #(
        .ADDR_BITS(34),
        .LEN_BITS(17),
        .CMD_LEN_BITS(32),
        .DATA_BITS(512),
        .CHUNK_BYTES(65536),
        .MAX_OUTSTANDING(2)
    ) dut (
        .aclk(clk),
        .aresetn(aresetn),
        .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr),
        .s_cmd_len(s_cmd_len),
        .m_req_valid(m_req_valid),
        .m_req_ready(m_req_ready),
        .m_req_paddr(m_req_paddr),
        .m_req_len(m_req_len),
        .req_done(req_done),
        .cmd_done(cmd_done),
        .busy(busy),
        .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    localparam int DLAT = 5;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          hs_n = 0;
    int          done_n = 0;
    logic [33:0] f_addr, l_addr;
    logic [16:0] f_len, l_len;
    bit          auto_done = 0;
    bit          done_at [0:1023];

    typedef struct {
        logic [33:0] addr;
        logic [31:0] len;
        int          n;
        logic [33:0] fa;
        logic [16:0] fl;
        logic [33:0] la;
        logic [16:0] ll;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Mid-cycle sample: records the handshake/cmd_done that the next rising edge will see.
    task automatic mon();
        @(negedge clk);
        if (aresetn && m_req_valid && m_req_ready) begin
            if (hs_n == 0) begin
                f_addr = m_req_paddr;
                f_len  = m_req_len;
            end
            l_addr = m_req_paddr;
            l_len  = m_req_len;
            hs_n++;
            if (auto_done) done_at[(cyc + DLAT) % 1024] = 1'b1;
        end
        if (cmd_done) done_n++;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_done) req_done = done_at[cyc % 1024];
        done_at[cyc % 1024] = 1'b0;
    endtask

    task automatic step();
        mon();
        nxt();
    endtask

    task automatic run_cmd(input logic [33:0] addr, input logic [31:0] len);
        bit acc;
        acc = 0;
        hs_n = 0;
        done_n = 0;
        auto_done = 1;
        m_req_ready = 1'b1;
        s_cmd_valid = 1'b1;
        s_cmd_addr = addr;
        s_cmd_len = len;
        for (int k = 0; k < 50 && !acc; k++) begin
            mon();
            acc = s_cmd_ready;
            nxt();
        end
        s_cmd_valid = 1'b0;
        chk("cmd_accept", 64'(acc), 64'd1);
        for (int k = 0; k < 3000 && done_n == 0; k++) step();
        repeat (4) step();
        auto_done = 0;
        req_done = 1'b0;
    endtask

    task automatic chk_row(input int i);
        chk($sformatf("row%0d chunks", i), 64'(hs_n), 64'(tbl[i].n));
        chk($sformatf("row%0d first_addr", i), 64'(f_addr), 64'(tbl[i].fa));
        chk($sformatf("row%0d first_len", i), 64'(f_len), 64'(tbl[i].fl));
        chk($sformatf("row%0d last_addr", i), 64'(l_addr), 64'(tbl[i].la));
        chk($sformatf("row%0d last_len", i), 64'(l_len), 64'(tbl[i].ll));
        chk($sformatf("row%0d cmd_done_cnt", i), 64'(done_n), 64'd1);
        chk($sformatf("row%0d idle_busy", i), 64'(busy), 64'd0);
    endtask

    initial begin
`ifdef CDMA_SPLIT_4K_EN
        tbl[0] = '{34'h0_0000_1000, 32'h0003_0000, 48, 34'h0_0000_1000, 17'h01000, 34'h0_0003_0000, 17'h01000};
        tbl[1] = '{34'h0_0000_0F00, 32'h0000_0300,  2, 34'h0_0000_0F00, 17'h00100, 34'h0_0000_1000, 17'h00200};
        tbl[2] = '{34'h0_0000_1234, 32'h0001_0050, 17, 34'h0_0000_1200, 17'h00E00, 34'h0_0001_1000, 17'h00240};
        tbl[3] = '{34'h3_FFFF_0000, 32'h0002_0000, 32, 34'h3_FFFF_0000, 17'h01000, 34'h0_0000_F000, 17'h01000};
`else
        tbl[0] = '{34'h0_0000_1000, 32'h0003_0000,  3, 34'h0_0000_1000, 17'h10000, 34'h0_0002_1000, 17'h10000};
        tbl[1] = '{34'h0_0000_0F00, 32'h0000_0300,  1, 34'h0_0000_0F00, 17'h00300, 34'h0_0000_0F00, 17'h00300};
        tbl[2] = '{34'h0_0000_1234, 32'h0001_0050,  2, 34'h0_0000_1200, 17'h10000, 34'h0_0001_1200, 17'h00040};
        tbl[3] = '{34'h3_FFFF_0000, 32'h0002_0000,  2, 34'h3_FFFF_0000, 17'h10000, 34'h0_0000_0000, 17'h10000};
`endif
        tbl[4] = '{34'h0_0000_0040, 32'h0000_0040,  1, 34'h0_0000_0040, 17'h00040, 34'h0_0000_0040, 17'h00040};

        aresetn = 1'b0;
        s_cmd_valid = 1'b0;
        s_cmd_addr = '0;
        s_cmd_len = '0;
        m_req_ready = 1'b0;
        req_done = 1'b0;

        // Reset state
        nxt();
        nxt();
        mon();
        chk("rst s_cmd_ready", 64'(s_cmd_ready), 64'd0);
        chk("rst m_req_valid", 64'(m_req_valid), 64'd0);
        chk("rst m_req_paddr", 64'(m_req_paddr), 64'd0);
        chk("rst m_req_len", 64'(m_req_len), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst outstanding", 64'(outstanding), 64'd0);
        chk("rst cmd_done", 64'(cmd_done), 64'd0);
        chk("rst err_underflow", 64'(err_underflow), 64'd0);
        nxt();
        aresetn = 1'b1;
        step();
        mon();
        chk("post_rst s_cmd_ready", 64'(s_cmd_ready), 64'd1);
        nxt();

        // Single-chunk latency: valid the cycle after accept, cmd_done 2 cycles after req_done
        s_cmd_valid = 1'b1;
        s_cmd_addr = 34'h40;
        s_cmd_len = 32'h40;
        m_req_ready = 1'b1;
        mon();
        chk("lat accept_ready", 64'(s_cmd_ready), 64'd1);
        nxt();
        s_cmd_valid = 1'b0;
        mon();
        chk("lat valid_next", 64'(m_req_valid), 64'd1);
        chk("lat paddr", 64'(m_req_paddr), 64'h40);
        chk("lat len", 64'(m_req_len), 64'h40);
        chk("lat cmd_ready_low", 64'(s_cmd_ready), 64'd0);
        nxt();
        req_done = 1'b1;
        mon();
        chk("lat valid_after_last", 64'(m_req_valid), 64'd0);
        chk("lat outstanding1", 64'(outstanding), 64'd1);
        chk("lat busy", 64'(busy), 64'd1);
        nxt();
        req_done = 1'b0;
        mon();
        chk("lat outstanding0", 64'(outstanding), 64'd0);
        chk("lat cmd_done_early", 64'(cmd_done), 64'd0);
        nxt();
        mon();
        chk("lat cmd_done", 64'(cmd_done), 64'd1);
        chk("lat busy_idle", 64'(busy), 64'd0);
        nxt();
        mon();
        chk("lat cmd_done_1cyc", 64'(cmd_done), 64'd0);
        chk("lat ready_again", 64'(s_cmd_ready), 64'd1);
        nxt();

        // Zero length after beat masking
        hs_n = 0;
        s_cmd_valid = 1'b1;
        s_cmd_addr = 34'h100;
        s_cmd_len = 32'h20;
        step();
        s_cmd_valid = 1'b0;
        mon();
        chk("zero cmd_done", 64'(cmd_done), 64'd1);
        chk("zero busy", 64'(busy), 64'd0);
        chk("zero m_req_valid", 64'(m_req_valid), 64'd0);
        nxt();
        mon();
        chk("zero cmd_done_1cyc", 64'(cmd_done), 64'd0);
        chk("zero no_chunks", 64'(hs_n), 64'd0);
        nxt();

        // Table-driven commands
        for (int i = 0; i < 5; i++) begin
            run_cmd(tbl[i].addr, tbl[i].len);
            chk_row(i);
        end

        // Handshake and req_done in the same cycle with one chunk in flight
        s_cmd_valid = 1'b1;
        s_cmd_addr = 34'h0;
        s_cmd_len = 32'h2_0000;
        m_req_ready = 1'b0;
        step();
        s_cmd_valid = 1'b0;
        m_req_ready = 1'b1;
        mon();
        chk("sim valid", 64'(m_req_valid), 64'd1);
        nxt();
        req_done = 1'b1;
        mon();
        chk("sim outstanding_before", 64'(outstanding), 64'd1);
        chk("sim valid2", 64'(m_req_valid), 64'd1);
        nxt();
        m_req_ready = 1'b0;
        mon();
        chk("sim outstanding_net0", 64'(outstanding), 64'd1);
        nxt();
        req_done = 1'b0;
        hs_n = 0;
        done_n = 0;
        auto_done = 1;
        m_req_ready = 1'b1;
        for (int k = 0; k < 3000 && done_n == 0; k++) step();
        auto_done = 0;
        req_done = 1'b0;
        chk("sim cmd_done", 64'(done_n), 64'd1);
        chk("sim err_clear", 64'(err_underflow), 64'd0);

        // Stray req_done while idle is sticky
        step();
        req_done = 1'b1;
        step();
        req_done = 1'b0;
        mon();
        chk("idle err_underflow", 64'(err_underflow), 64'd1);
        chk("idle outstanding", 64'(outstanding), 64'd0);
        nxt();
        run_cmd(tbl[4].addr, tbl[4].len);
        chk_row(4);
        chk("err sticky", 64'(err_underflow), 64'd1);

        // Outstanding cap of 2, release one per done, hold while stalled, reset mid-ISSUE
        hs_n = 0;
        m_req_ready = 1'b1;
        s_cmd_valid = 1'b1;
        s_cmd_addr = 34'h0;
        s_cmd_len = 32'h4_0000;
        step();
        s_cmd_valid = 1'b0;
        repeat (10) step();
        mon();
        chk("cap issued", 64'(hs_n), 64'd2);
        chk("cap valid_low", 64'(m_req_valid), 64'd0);
        chk("cap outstanding", 64'(outstanding), 64'd2);
        nxt();
        req_done = 1'b1;
        step();
        req_done = 1'b0;
        repeat (6) step();
        mon();
        chk("cap release_one", 64'(hs_n), 64'd3);
        chk("cap outstanding2", 64'(outstanding), 64'd2);
        nxt();
        m_req_ready = 1'b0;
        req_done = 1'b1;
        step();
        req_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mon();
            chk($sformatf("hold%0d valid", k), 64'(m_req_valid), 64'd1);
`ifdef CDMA_SPLIT_4K_EN
            chk($sformatf("hold%0d paddr", k), 64'(m_req_paddr), 64'h3000);
            chk($sformatf("hold%0d len", k), 64'(m_req_len), 64'h1000);
`else
            chk($sformatf("hold%0d paddr", k), 64'(m_req_paddr), 64'h3_0000);
            chk($sformatf("hold%0d len", k), 64'(m_req_len), 64'h1_0000);
`endif
            nxt();
        end
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        mon();
        chk("mrst m_req_valid", 64'(m_req_valid), 64'd0);
        chk("mrst m_req_paddr", 64'(m_req_paddr), 64'd0);
        chk("mrst m_req_len", 64'(m_req_len), 64'd0);
        chk("mrst outstanding", 64'(outstanding), 64'd0);
        chk("mrst busy", 64'(busy), 64'd0);
        chk("mrst err_underflow", 64'(err_underflow), 64'd0);
        chk("mrst s_cmd_ready", 64'(s_cmd_ready), 64'd0);
        nxt();
        mon();
        chk("mrst ready_after", 64'(s_cmd_ready), 64'd1);
        nxt();
        req_done = 1'b1;
        step();
        req_done = 1'b0;
        mon();
        chk("stale err_underflow", 64'(err_underflow), 64'd1);
        nxt();
        run_cmd(tbl[0].addr, tbl[0].len);
        chk_row(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
